// File: rtl/shifter8_pkg.sv
// rtl/shifter8_pkg.sv - shared op codes, state encoding and helpers for the shifter sequencer
//
// Purpose : op-code constants understood by the 8-bit shifter register, the
//           sequencer state encoding, and the largest shift the datapath can
//           perform in a single cycle.
// Ports   : none (package)

package shifter8_pkg;

   // Op codes driven onto the shifter's op input
   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_LSL  = 3'b010;
   localparam logic [2:0] OP_LSR  = 3'b011;
   localparam logic [2:0] OP_ASR  = 3'b100;

   // Widest shift the datapath applies in one cycle (fits the 2-bit shamt)
   localparam int unsigned MAX_STEP = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // True for the three directional shift codes
   function automatic logic is_shift_op(input logic [2:0] i_op);
      return (i_op == OP_LSL) || (i_op == OP_LSR) || (i_op == OP_ASR);
   endfunction

   // Codes above ASR are not defined for the shifter
   function automatic logic is_legal_op(input logic [2:0] i_op);
      return (i_op <= OP_ASR);
   endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - splits a remaining shift count into one per-cycle step
//
// Purpose : combinational step slicer. Given the shift still outstanding it
//           returns the amount to apply this cycle, min(rem, MAX_STEP), and
//           the count left over afterwards.
// Ports   : i_rem       in  AMT_W  remaining shift amount
//           o_shamt     out 2      amount to shift this cycle
//           o_rem_next  out AMT_W  remaining amount after this step

module shift_step
   import shifter8_pkg::*;
#(
   parameter int AMT_W = 3
) (
   input  logic [AMT_W-1:0] i_rem,
   output logic [1:0]       o_shamt,
   output logic [AMT_W-1:0] o_rem_next
);

   // Work at no less than 2 bits so the comparison against MAX_STEP and the
   // 2-bit step slice stay legal even for a 1-bit amount field.
   localparam int EXT_W = (AMT_W < 2) ? 2 : AMT_W;

   logic [EXT_W-1:0] w_rem_ext;
   logic [EXT_W-1:0] w_max_ext;
   logic [EXT_W-1:0] w_step_ext;
   logic [EXT_W-1:0] w_left_ext;

   assign w_rem_ext  = EXT_W'(i_rem);
   assign w_max_ext  = EXT_W'(MAX_STEP);
   assign w_step_ext = (w_rem_ext > w_max_ext) ? w_max_ext : w_rem_ext;
   assign w_left_ext = w_rem_ext - w_step_ext;

   assign o_shamt    = w_step_ext[1:0];
   assign o_rem_next = AMT_W'(w_left_ext);

endmodule

// File: rtl/shifter8_ctrl.sv
// rtl/shifter8_ctrl.sv - command sequencer driving the 8-bit shifter's op/shamt inputs
//
// Purpose : accepts one shift command at a time over valid/ready, breaks
//           long shifts into steps of at most MAX_STEP, and reports
//           completion with a one-cycle done pulse (err flags illegal ops).
// Ports   : clk        in  1      system clock, rising edge
//           reset_n    in  1      asynchronous active-low reset
//           cmd_valid  in  1      command present
//           cmd_ready  out 1      controller idle, can accept a command
//           cmd_op     in  3      NOP/LOAD/LSL/LSR/ASR, 101..111 illegal
//           cmd_amt    in  AMT_W  total shift amount (ignored for NOP/LOAD)
//           op         out 3      registered op code to the shifter
//           shamt      out 2      registered per-cycle shift amount
//           busy       out 1      high whenever not IDLE
//           done       out 1      one-cycle completion pulse
//           err        out 1      with done, completed command was illegal

module shifter8_ctrl
   import shifter8_pkg::*;
#(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [AMT_W-1:0] cmd_amt,
   output logic [2:0]       op,
   output logic [1:0]       shamt,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           r_state;
   logic [2:0]       r_op;
   logic [1:0]       r_shamt;
   logic [AMT_W-1:0] r_rem;
   logic             r_done;
   logic             r_err;

   state_t           w_state_nxt;
   logic [2:0]       w_op_nxt;
   logic [1:0]       w_shamt_nxt;
   logic [AMT_W-1:0] w_rem_nxt;
   logic             w_done_nxt;
   logic             w_err_nxt;

   logic             w_accept;
   logic [AMT_W-1:0] w_step_in;
   logic [1:0]       w_step_shamt;
   logic [AMT_W-1:0] w_step_rem;

   assign w_accept = cmd_valid && (r_state == ST_IDLE);

   // r_rem holds what is left *after* the step currently on op/shamt, so
   // the single slicer is fed from the fresh command while idle and from
   // r_rem while shifting.
   assign w_step_in = (r_state == ST_IDLE) ? cmd_amt : r_rem;

   shift_step #(
      .AMT_W (AMT_W)
   ) u_shift_step (
      .i_rem      (w_step_in),
      .o_shamt    (w_step_shamt),
      .o_rem_next (w_step_rem)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_op    <= OP_NOP;
         r_shamt <= 2'b00;
         r_rem   <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_op    <= w_op_nxt;
         r_shamt <= w_shamt_nxt;
         r_rem   <= w_rem_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
      end
   end

   // Next state together with the values op/shamt/done/err take in that
   // state, so the outputs are registered and line up with the state.
   always_comb begin
      w_state_nxt = r_state;
      w_op_nxt    = OP_NOP;
      w_shamt_nxt = 2'b00;
      w_rem_nxt   = r_rem;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (cmd_op == OP_LOAD) begin
                  w_state_nxt = ST_LOAD;
                  w_op_nxt    = OP_LOAD;
                  w_rem_nxt   = '0;
               end else if (is_shift_op(cmd_op) && (cmd_amt != '0)) begin
                  w_state_nxt = ST_SHIFT;
                  w_op_nxt    = cmd_op;
                  w_shamt_nxt = w_step_shamt;
                  w_rem_nxt   = w_step_rem;
               end else begin
                  // NOP, zero-length shift or illegal code: nothing reaches
                  // the shifter, complete straight away.
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
                  w_err_nxt   = !is_legal_op(cmd_op);
                  w_rem_nxt   = '0;
               end
            end
         end

         ST_LOAD: begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
         end

         ST_SHIFT: begin
            if (r_rem == '0) begin
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
            end else begin
               // r_op still carries the direction latched at acceptance
               w_op_nxt    = r_op;
               w_shamt_nxt = w_step_shamt;
               w_rem_nxt   = w_step_rem;
            end
         end

         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign op        = r_op;
   assign shamt     = r_shamt;
   assign done      = r_done;
   assign err       = r_err;

endmodule

// File: tb/tb_shifter8_ctrl.sv
// tb/tb_shifter8_ctrl.sv - self-checking bench for shifter8_ctrl with a shifter register model

module tb_shifter8_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_amt;
   logic [2:0] op;
   logic [1:0] shamt;
   logic       busy;
   logic       done;
   logic       err;

   logic [7:0] d_in  = 8'h00;
   logic [7:0] sh_q  = 8'h00;
   logic [7:0] exp_q = 8'h00;

   int tests = 0;
   int fails = 0;

   shifter8_ctrl #(.AMT_W(3)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_amt   (cmd_amt),
      .op        (op),
      .shamt     (shamt),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Behavioural 8-bit shifter register fed by the controller
   always @(posedge clk) begin
      case (op)
         3'b001:  sh_q <= d_in;
         3'b010:  sh_q <= sh_q << shamt;
         3'b011:  sh_q <= sh_q >> shamt;
         3'b100:  sh_q <= 8'($signed(sh_q) >>> shamt);
         default: sh_q <= sh_q;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
      $fatal(1);
   end

   // Net effect of a whole command on the register value
   function automatic logic [7:0] ref_result(input logic [2:0] c_op, input logic [2:0] c_amt,
                                              input logic [7:0] din, input logic [7:0] cur);
      logic [7:0] r;
      case (c_op)
         3'd1:    r = din;
         3'd2:    r = cur << c_amt;
         3'd3:    r = cur >> c_amt;
         3'd4:    r = 8'($signed(cur) >>> c_amt);
         default: r = cur;
      endcase
      return r;
   endfunction

   // Wait for ready, present a command, return after the acceptance edge (#1)
   task automatic send(input logic [2:0] c_op, input logic [2:0] c_amt, input logic [7:0] din,
                       input bit hold, output int waited);
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      tests++;
      if (cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL send_ready: cmd_ready=%b after %0d cycles, want 1", cmd_ready, waited);
      end
      cmd_valid = 1'b1;
      cmd_op    = c_op;
      cmd_amt   = c_amt;
      d_in      = din;
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
   endtask

   // Check step-by-step trace from cycle T+1 through the done cycle
   task automatic expect_cmd(input logic [2:0] c_op, input logic [2:0] c_amt, input logic [7:0] din,
                             input bit scramble, input string name);
      int         steps[$];
      int         n;
      logic [2:0] step_op;
      logic       illegal;
      illegal = (c_op > 3'd4);
      step_op = 3'd0;
      if (c_op == 3'd1) begin
         steps.push_back(0);
         step_op = 3'd1;
      end else if (c_op >= 3'd2 && c_op <= 3'd4) begin
         n = c_amt;
         while (n > 0) begin
            steps.push_back((n > 3) ? 3 : n);
            n -= (n > 3) ? 3 : n;
         end
         step_op = c_op;
      end
      foreach (steps[i]) begin
         if (scramble) begin
            cmd_op  = 3'($urandom);
            cmd_amt = 3'($urandom);
         end
         tests++;
         if (op !== step_op || shamt !== 2'(steps[i]) || done !== 1'b0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s step%0d: op=%0d shamt=%0d done=%b busy=%b ready=%b, want op=%0d shamt=%0d done=0 busy=1 ready=0",
                     name, i, op, shamt, done, busy, cmd_ready, step_op, steps[i]);
         end
         @(posedge clk); #1;
      end
      if (scramble) begin
         cmd_op  = 3'($urandom);
         cmd_amt = 3'($urandom);
      end
      tests++;
      if (done !== 1'b1 || err !== illegal || op !== 3'd0 || shamt !== 2'd0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL %s done_cycle: done=%b err=%b op=%0d shamt=%0d busy=%b ready=%b, want done=1 err=%b op=0 shamt=0 busy=1 ready=0",
                  name, done, err, op, shamt, busy, cmd_ready, illegal);
      end
      exp_q = ref_result(c_op, c_amt, din, exp_q);
   endtask

   // Cycle after done: back to idle, register holds the expected result
   task automatic finish_cmd(input string name);
      @(posedge clk); #1;
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
          op !== 3'd0 || shamt !== 2'd0 || sh_q !== exp_q) begin
         fails++;
         $display("FAIL %s idle_after: ready=%b busy=%b done=%b err=%b op=%0d shamt=%0d q=%h, want 1 0 0 0 0 0 q=%h",
                  name, cmd_ready, busy, done, err, op, shamt, sh_q, exp_q);
      end
   endtask

   task automatic run(input logic [2:0] c_op, input logic [2:0] c_amt, input logic [7:0] din, input string name);
      int w;
      send(c_op, c_amt, din, 1'b0, w);
      expect_cmd(c_op, c_amt, din, 1'b0, name);
      finish_cmd(name);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 3'd0;
      cmd_amt   = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      tests++;
      if (op !== 3'd0 || shamt !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_state: op=%0d shamt=%0d busy=%b done=%b err=%b ready=%b, want 0 0 0 0 0 1",
                  op, shamt, busy, done, err, cmd_ready);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      tests++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL reset_release: ready=%b busy=%b done=%b, want 1 0 0", cmd_ready, busy, done);
      end
   endtask

   task automatic test_load_lsl7();
      run(3'd1, 3'd0, 8'b0000_0001, "load");
      run(3'd2, 3'd7, 8'b0000_0001, "lsl7");
   endtask

   task automatic test_asr5();
      run(3'd4, 3'd5, 8'h00, "asr5");
   endtask

   task automatic test_lsr0();
      run(3'd3, 3'd0, 8'h5A, "lsr0");
   endtask

   task automatic test_illegal();
      run(3'b110, 3'd5, 8'hFF, "illegal110");
      run(3'b111, 3'd0, 8'hFF, "illegal111");
      run(3'd0, 3'd6, 8'hFF, "nop");
   endtask

   task automatic test_back_to_back();
      int w;
      run(3'd1, 3'd0, 8'h3C, "b2b_load");
      send(3'd2, 3'd4, 8'h3C, 1'b1, w);
      expect_cmd(3'd2, 3'd4, 8'h3C, 1'b1, "b2b_first");
      send(3'd4, 3'd2, 8'h3C, 1'b0, w);
      tests++;
      if (w !== 1) begin
         fails++;
         $display("FAIL b2b_accept_cycle: ready came %0d cycles after done, want 1", w);
      end
      expect_cmd(3'd4, 3'd2, 8'h3C, 1'b0, "b2b_second");
      finish_cmd("b2b_second");
   endtask

   task automatic test_reset_mid();
      int         w;
      logic [7:0] base;
      run(3'd1, 3'd0, 8'b0000_0011, "mid_load");
      base = exp_q;
      send(3'd2, 3'd7, 8'h00, 1'b0, w);
      tests++;
      if (op !== 3'd2 || shamt !== 2'd3) begin
         fails++;
         $display("FAIL mid_first_step: op=%0d shamt=%0d, want 2 3", op, shamt);
      end
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      tests++;
      if (op !== 3'd0 || shamt !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL mid_async_reset: op=%0d shamt=%0d busy=%b done=%b ready=%b, want 0 0 0 0 1",
                  op, shamt, busy, done, cmd_ready);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         tests++;
         if (done !== 1'b0 || op !== 3'd0) begin
            fails++;
            $display("FAIL mid_no_done: cycle %0d done=%b op=%0d, want 0 0", i, done, op);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      exp_q = base << 3;
      tests++;
      if (cmd_ready !== 1'b1 || done !== 1'b0 || sh_q !== exp_q) begin
         fails++;
         $display("FAIL mid_release: ready=%b done=%b q=%h, want 1 0 q=%h", cmd_ready, done, sh_q, exp_q);
      end
   endtask

   task automatic test_random();
      logic [2:0] r_op;
      logic [2:0] r_amt;
      logic [7:0] r_din;
      for (int k = 0; k < 40; k++) begin
         r_op  = 3'($urandom_range(0, 7));
         r_amt = 3'($urandom_range(0, 7));
         r_din = 8'($urandom);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run(r_op, r_amt, r_din, "random");
      end
   endtask

   initial begin
      test_reset();
      test_load_lsl7();
      test_asr5();
      test_lsr0();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
